// File: rtl/gpio_bus_initiator.sv
// Bus initiator for the LED/switch GPIO slave: scans the four input registers
// into a snapshot on irq, timer or reset, and turns masked LED requests into single-bit writes.
module gpio_bus_initiator #(
    parameter int POLL_PERIOD = 1000,
    parameter int CW          = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  a_o,
    output logic [31:0] d_o,
    output logic        we_o,
    input  logic [31:0] spo_i,
    input  logic        irq_i,
    input  logic        led_valid,
    input  logic [3:0]  led_val,
    input  logic [3:0]  led_mask,
    output logic        led_ready,
    output logic [3:0]  snap,
    output logic [3:0]  changed,
    output logic        snap_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] val_q, val_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] snap_q, snap_d;
    logic [3:0] changed_q, changed_d;
    logic       snap_valid_q, snap_valid_d;
    logic       pending_q, pending_d;
    logic       pend_clr;
    logic       poll_hit;
    logic [1:0] sel;
    logic       unused_spo;

    assign unused_spo = ^spo_i[31:1];

    generate
        if (POLL_PERIOD > 0) begin : g_poll
            localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);
            logic [CW-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst || cnt_q == LAST) cnt_q <= '0;
                else                      cnt_q <= cnt_q + 1'b1;
            end
            assign poll_hit = (cnt_q == LAST);
        end else begin : g_nopoll
            assign poll_hit = 1'b0;
        end
    endgenerate

    // A new event in the same cycle as the clear keeps the bit set, forcing a rescan.
    assign pending_d = (pending_q & ~pend_clr) | irq_i | poll_hit;

    // Lowest remaining mask bit is the next LED to write.
    always_comb begin
        sel = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (rem_q[i]) sel = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        val_d        = val_q;
        rem_d        = rem_q;
        shadow_d     = shadow_q;
        snap_d       = snap_q;
        changed_d    = changed_q;
        snap_valid_d = 1'b0;
        pend_clr     = 1'b0;
        a_o          = 4'd0;
        d_o          = 32'd0;
        we_o         = 1'b0;
        led_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                led_ready = ~rst;
                if (led_valid) begin
                    val_d   = led_val;
                    rem_d   = led_mask;
                    state_d = WR;
                end else if (pending_q) begin
                    pend_clr = 1'b1;
                    idx_d    = 2'd0;
                    state_d  = RD;
                end
            end
            RD: begin
                // idx 0..3 maps to addresses 0,1,4,5
                a_o             = {1'b0, idx_q[1], 1'b0, idx_q[0]};
                shadow_d[idx_q] = spo_i[0];
                idx_d           = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                snap_d       = shadow_q;
                changed_d    = shadow_q ^ snap_q;
                snap_valid_d = 1'b1;
                state_d      = IDLE;
            end
            WR: begin
                if (|rem_q) begin
                    a_o        = 4'd6 + {2'b00, sel};
                    we_o       = 1'b1;
                    d_o[24]    = val_q[sel];
                    rem_d[sel] = 1'b0;
                end
                if (rem_d == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            val_q        <= 4'd0;
            rem_q        <= 4'd0;
            shadow_q     <= 4'd0;
            snap_q       <= 4'd0;
            changed_q    <= 4'd0;
            snap_valid_q <= 1'b0;
            pending_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            rem_q        <= rem_d;
            shadow_q     <= shadow_d;
            snap_q       <= snap_d;
            changed_q    <= changed_d;
            snap_valid_q <= snap_valid_d;
            pending_q    <= pending_d;
        end
    end

    assign snap       = snap_q;
    assign changed    = changed_q;
    assign snap_valid = snap_valid_q;
    assign busy       = (state_q != IDLE);

endmodule
